// File: rtl/spi_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_bist_pkg
// Description : FSM state encodings, status codes and LFSR definition for the
//               SPI loopback BIST.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_st_idle  = 3'd0;
  localparam state_t c_st_load  = 3'd1;
  localparam state_t c_st_shift = 3'd2;
  localparam state_t c_st_check = 3'd3;
  localparam state_t c_st_done  = 3'd4;

  localparam logic [2:0] c_code_idle      = 3'b000;
  localparam logic [2:0] c_code_shift     = 3'b001;
  localparam logic [2:0] c_code_pass      = 3'b010;
  localparam logic [2:0] c_code_fail      = 3'b011;
  localparam logic [2:0] c_code_done_pass = 3'b100;
  localparam logic [2:0] c_code_done_fail = 3'b101;

  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [7:0] c_lfsr_taps  = 8'b1011_1000;
  localparam logic [7:0] c_default_seed = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] value);
    return {value[6:0], ^(value & c_lfsr_taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_loopback_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_loopback_bist_if
// Description : Observation bus of the SPI loopback BIST (SPI pins + status).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_loopback_bist_if;
  logic       S_cs;
  logic       S_s_clk;
  logic [7:0] data_out;
  logic [3:0] counter;
  logic [2:0] Code;
  logic [7:0] L_data;

  modport master (output S_cs, S_s_clk, data_out, counter, Code, L_data);
  modport slave  (input  S_cs, S_s_clk, data_out, counter, Code, L_data);
endinterface
`default_nettype wire

// File: rtl/spi_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : spi_bist_lfsr
// Description : 8-bit Fibonacci LFSR with synchronous seed load and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bist_lfsr
  import spi_bist_pkg::*;
#(
  parameter logic [7:0] SEED = c_default_seed
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       i_load,
  input  wire logic       i_en,
  output logic [7:0]      o_value
);

  logic [7:0] r_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= SEED;
    end else if (i_load) begin
      r_value <= SEED;
    end else if (i_en) begin
      r_value <= lfsr_next(r_value);
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/spi_loopback_bist.sv
`default_nettype none
// ============================================================================
// Module      : spi_loopback_bist
// Description : SPI mode-0 master looped back into an internal slave, fed by
//               an LFSR; every frame is compared and a status code reported.
//               Option macro: SPI_BIST_FAULT_INJECT_EN (corrupts frame 3).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_loopback_bist
  import spi_bist_pkg::*;
#(
  parameter int unsigned  CLK_DIV      = 1,
  parameter int unsigned  NUM_PATTERNS = 16,
  parameter logic [7:0]   SEED         = c_default_seed
) (
  input  wire logic            clk,
  input  wire logic            reset,
  spi_loopback_bist_if.master  bus
);

  localparam int unsigned c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned c_fc_w  = $clog2(NUM_PATTERNS + 1);

  state_t              r_state;
  logic [7:0]          r_tx;
  logic [7:0]          r_rx;
  logic [7:0]          r_data_out;
  logic [3:0]          r_counter;
  logic                r_sclk;
  logic                r_fail;
  logic [c_div_w-1:0]  r_div;
  logic [c_fc_w-1:0]   r_frame_cnt;

  logic [7:0]          w_lfsr;
  logic                w_tick;
  logic                w_fault;
  logic                w_mosi;
  logic                w_cs;
  logic [2:0]          w_code;

  spi_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (r_state == c_st_idle),
    .i_en    (r_state == c_st_check),
    .o_value (w_lfsr)
  );

`ifdef SPI_BIST_FAULT_INJECT_EN
  assign w_fault = (r_frame_cnt == c_fc_w'(3));
`else
  assign w_fault = 1'b0;
`endif

  assign w_tick = (r_div == c_div_w'(CLK_DIV - 1));
  assign w_mosi = r_tx[7] ^ w_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_tx        <= 8'h00;
      r_rx        <= 8'h00;
      r_data_out  <= 8'h00;
      r_counter   <= 4'd0;
      r_sclk      <= 1'b0;
      r_fail      <= 1'b0;
      r_div       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_state <= c_st_load;
        end
        c_st_load: begin
          r_tx      <= w_lfsr;
          r_counter <= 4'd0;
          r_div     <= '0;
          r_sclk    <= 1'b0;
          r_state   <= c_st_shift;
        end
        c_st_shift: begin
          if (w_tick) begin
            r_div <= '0;
            if (!r_sclk) begin
              // Rising edge: slave samples MOSI.
              r_sclk    <= 1'b1;
              r_rx      <= {r_rx[6:0], w_mosi};
              r_counter <= r_counter + 4'd1;
            end else begin
              // Falling edge: master presents the next bit.
              r_sclk <= 1'b0;
              r_tx   <= {r_tx[6:0], 1'b0};
              if (r_counter == 4'd8) begin
                r_state <= c_st_check;
              end
            end
          end else begin
            r_div <= r_div + c_div_w'(1);
          end
        end
        c_st_check: begin
          r_data_out  <= r_rx;
          r_frame_cnt <= r_frame_cnt + c_fc_w'(1);
          if (r_rx != w_lfsr) begin
            r_fail <= 1'b1;
          end
          if (r_frame_cnt == c_fc_w'(NUM_PATTERNS - 1)) begin
            r_state <= c_st_done;
          end else begin
            r_state <= c_st_load;
          end
        end
        c_st_done: begin
          r_state <= c_st_done;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  always_comb begin
    w_cs   = 1'b1;
    w_code = c_code_idle;
    case (r_state)
      c_st_load: begin
        w_cs   = 1'b0;
      end
      c_st_shift: begin
        w_cs   = 1'b0;
        w_code = c_code_shift;
      end
      c_st_check: begin
        w_code = (r_rx == w_lfsr) ? c_code_pass : c_code_fail;
      end
      c_st_done: begin
        w_code = r_fail ? c_code_done_fail : c_code_done_pass;
      end
      default: begin
        w_cs   = 1'b1;
        w_code = c_code_idle;
      end
    endcase
  end

  assign bus.S_cs     = w_cs;
  assign bus.S_s_clk  = r_sclk;
  assign bus.data_out = r_data_out;
  assign bus.counter  = r_counter;
  assign bus.Code     = w_code;
  assign bus.L_data   = w_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_spi_loopback_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_loopback_bist
// Description : Self-checking bench for spi_loopback_bist with a byte-level
//               reference model of the LFSR sequence and frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_loopback_bist;

  localparam int c_frames = 16;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   cyc;

  spi_loopback_bist_if bus ();

  spi_loopback_bist #(
    .CLK_DIV      (1),
    .NUM_PATTERNS (c_frames),
    .SEED         (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"},       bus.S_cs,     1);
    check({tag, "_sclk"},     bus.S_s_clk,  0);
    check({tag, "_code"},     bus.Code,     0);
    check({tag, "_ldata"},    bus.L_data,   8'hA5);
    check({tag, "_counter"},  bus.counter,  0);
    check({tag, "_data_out"}, bus.data_out, 0);
  endtask

  // Follows one frame from LOAD through CHECK and the cycle after it.
  task automatic run_frame(input logic [7:0] sent, input bit exp_fail, output int load_cyc);
    int   guard;
    int   rises;
    logic prev;
    guard = 0;
    while (bus.S_cs !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("load_timeout", (guard < 100), 1);
    load_cyc = cyc;
    check("load_code", bus.Code, 3'b000);
    check("load_sclk", bus.S_s_clk, 0);
    rises = 0;
    prev  = 1'b0;
    guard = 0;
    @(negedge clk);
    check("shift_code", bus.Code, 3'b001);
    while (bus.S_cs === 1'b0 && guard < 200) begin
      if (bus.S_s_clk === 1'b1 && prev === 1'b0) begin
        rises++;
        check("shift_counter", bus.counter, rises);
      end
      prev = bus.S_s_clk;
      @(negedge clk);
      guard++;
    end
    check("shift_timeout", (guard < 200), 1);
    check("shift_period", guard, 16);
    check("rises", rises, 8);
    check("check_counter", bus.counter, 8);
    check("check_code", bus.Code, exp_fail ? 3'b011 : 3'b010);
    check("check_ldata", bus.L_data, sent);
    @(negedge clk);
    check("data_out", bus.data_out, exp_fail ? ~sent : sent);
    check("ldata_next", bus.L_data, model_next(sent));
  endtask

  initial begin
    logic [7:0] l;
    logic [7:0] last;
    bit         any_fail;
    bit         exp_fail;
    int         lc0;
    int         lc1;
    int         k;

    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b0;

    // Reset values while held.
    #12;
    check_reset_values("reset");
    #8;
    reset = 1'b1;

    // Full run against the reference LFSR sequence.
    l        = 8'hA5;
    last     = 8'h00;
    any_fail = 1'b0;
    lc1      = 0;
    for (int i = 0; i < c_frames; i++) begin
`ifdef SPI_BIST_FAULT_INJECT_EN
      exp_fail = (i == 3);
`else
      exp_fail = 1'b0;
`endif
      lc0 = lc1;
      run_frame(l, exp_fail, lc1);
      if (i == 1) check("frame_period", lc1 - lc0, 18);
      any_fail = any_fail | exp_fail;
      last     = exp_fail ? ~l : l;
      l        = model_next(l);
    end

    check("done_code", bus.Code, any_fail ? 3'b101 : 3'b100);
    check("done_cs", bus.S_cs, 1);
    k = int'($urandom_range(40, 5));
    repeat (k) @(negedge clk);
    check("frozen_code", bus.Code, any_fail ? 3'b101 : 3'b100);
    check("frozen_cs", bus.S_cs, 1);
    check("frozen_sclk", bus.S_s_clk, 0);
    check("frozen_data_out", bus.data_out, last);
    check("frozen_ldata", bus.L_data, l);
    check("frozen_counter", bus.counter, 8);

    // Restart, then abort frame 2 mid-SHIFT.
    reset = 1'b0;
    #1;
    check_reset_values("rerun_reset");
    @(negedge clk);
    reset = 1'b1;
    run_frame(8'hA5, 1'b0, lc0);
    k = int'($urandom_range(15, 1));
    repeat (k) @(negedge clk);
    check("abort_in_shift_cs", bus.S_cs, 0);
    check("abort_in_shift_code", bus.Code, 3'b001);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    check_reset_values("abort_hold");
    reset = 1'b1;
    run_frame(8'hA5, 1'b0, lc0);
    run_frame(8'h4A, 1'b0, lc1);
    check("restart_period", lc1 - lc0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
